// File: rtl/masked_arb_pkg.sv
// Shared types and helpers for masked_lane_arbiter: FSM state encoding and
// the per-lane enable test evaluated at elaboration time.
package masked_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DEFAULT_MAX_SIZE = 3;
  localparam int MASK_W           = 64;

  // Callers only reach the mask select for lanes below size.
  function automatic logic lane_enabled(input int g, input int size,
                                        input logic [MASK_W-1:0] mask);
    return (g < size) && mask[g[5:0]];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible lane at or after ptr,
// wrapping at SIZE, returned as one-hot pick and binary pick_id.
module rr_pick #(
  parameter int MAX_SIZE = 3,
  parameter int SIZE     = 3,
  parameter int ID_W     = 2
) (
  input  logic [MAX_SIZE-1:0] elig,
  input  logic [ID_W-1:0]     ptr,
  output logic [MAX_SIZE-1:0] pick,
  output logic [ID_W-1:0]     pick_id
);

  always_comb begin
    int              idx;
    logic            found;
    logic [ID_W-1:0] sel;
    pick    = '0;
    pick_id = '0;
    found   = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 0; k < SIZE; k++) begin
      idx = int'(ptr) + k;
      if (idx >= SIZE) idx = idx - SIZE;
      sel = ID_W'(idx);
      if (!found && elig[sel]) begin
        found     = 1'b1;
        pick[sel] = 1'b1;
        pick_id   = sel;
      end
    end
  end

endmodule

// File: rtl/masked_lane_arbiter.sv
// Round-robin arbiter over SIZE masked lanes with a request/done handshake.
// Define MASKED_ARB_TIMEOUT_EN to add a forced release after TIMEOUT busy cycles.
module masked_lane_arbiter
  import masked_arb_pkg::*;
#(
  parameter int                  MAX_SIZE = DEFAULT_MAX_SIZE,
  parameter int                  SIZE     = DEFAULT_MAX_SIZE,
  parameter logic [MAX_SIZE-1:0] MASK     = '1,
  parameter int                  TIMEOUT  = 15,
  localparam int                 ID_W     = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [MAX_SIZE-1:0] req,
  input  logic [MAX_SIZE-1:0] done,
  output logic [MAX_SIZE-1:0] gnt,
  output logic                gnt_valid,
  output logic [ID_W-1:0]     gnt_id
`ifdef MASKED_ARB_TIMEOUT_EN
  ,
  output logic                timeout
`endif
);

  if (SIZE < 1 || SIZE > MAX_SIZE || TIMEOUT < 1) begin : g_bad_cfg
    $error("masked_lane_arbiter: illegal SIZE or TIMEOUT");
  end

  logic [MAX_SIZE-1:0] elig;
  logic [MAX_SIZE-1:0] pick;
  logic [ID_W-1:0]     pick_id;

  // The mask bit of lanes at or above SIZE is never referenced.
  for (genvar g = 0; g < MAX_SIZE; g++) begin : g_lane
    if (g < SIZE) begin : g_act
      if (lane_enabled(g, SIZE, MASK_W'(MASK))) begin : g_on
        assign elig[g] = req[g];
      end else begin : g_off
        assign elig[g] = 1'b0;
      end
    end else begin : g_out
      assign elig[g] = 1'b0;
    end
  end

  arb_state_e          state_q, state_d;
  logic                run_q;
  logic [MAX_SIZE-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic                release_c;

`ifdef MASKED_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  rr_pick #(
    .MAX_SIZE(MAX_SIZE),
    .SIZE    (SIZE),
    .ID_W    (ID_W)
  ) u_pick (
    .elig   (elig),
    .ptr    (ptr_q),
    .pick   (pick),
    .pick_id(pick_id)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    release_c = 1'b0;
`ifdef MASKED_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // run_q holds off arbitration for the first edge after reset release.
        if (run_q && |elig) begin
          state_d = BUSY;
          gnt_d   = pick;
          id_d    = pick_id;
`ifdef MASKED_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        release_c = done[id_q];
`ifdef MASKED_ARB_TIMEOUT_EN
        if (!release_c && cnt_q == CNT_W'(TIMEOUT - 1)) begin
          release_c = 1'b1;
          timeout_d = 1'b1;
        end
        cnt_d = cnt_q + 1'b1;
`endif
        if (release_c) begin
          state_d = IDLE;
          gnt_d   = '0;
          id_d    = '0;
          ptr_d   = (id_q == ID_W'(SIZE - 1)) ? '0 : id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      run_q     <= 1'b0;
      gnt_q     <= '0;
      id_q      <= '0;
      ptr_q     <= '0;
`ifdef MASKED_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
`ifdef MASKED_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_id    = id_q;
`ifdef MASKED_ARB_TIMEOUT_EN
  assign timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_masked_lane_arbiter.sv
// Scoreboard bench for masked_lane_arbiter: three configurations share one
// reference model; expectations are queued at drive time and checked per cycle.
module tb_masked_lane_arbiter;

  localparam int N  = 3;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] req  [N];
  logic [2:0] done [N];
  logic [2:0] gnt  [N];
  logic       gv   [N];
  logic [1:0] gid  [N];
`ifdef MASKED_ARB_TIMEOUT_EN
  logic       tmo  [N];
`endif

  masked_lane_arbiter #(.MAX_SIZE(3), .SIZE(2), .MASK(3'b111), .TIMEOUT(TO)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .done(done[0]),
    .gnt(gnt[0]), .gnt_valid(gv[0]), .gnt_id(gid[0])
`ifdef MASKED_ARB_TIMEOUT_EN
    , .timeout(tmo[0])
`endif
  );

  masked_lane_arbiter #(.MAX_SIZE(3), .SIZE(3), .MASK(3'b101), .TIMEOUT(TO)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .done(done[1]),
    .gnt(gnt[1]), .gnt_valid(gv[1]), .gnt_id(gid[1])
`ifdef MASKED_ARB_TIMEOUT_EN
    , .timeout(tmo[1])
`endif
  );

  masked_lane_arbiter #(.MAX_SIZE(3), .SIZE(1), .MASK(3'b111), .TIMEOUT(TO)) u_c (
    .clk(clk), .rst_n(rst_n), .req(req[2]), .done(done[2]),
    .gnt(gnt[2]), .gnt_valid(gv[2]), .gnt_id(gid[2])
`ifdef MASKED_ARB_TIMEOUT_EN
    , .timeout(tmo[2])
`endif
  );

  // Reference model: owner -1 means idle.
  int         sz [N];
  logic [2:0] mk [N];
  int         owner [N];
  int         ptr   [N];
  int         hold  [N];
  bit         armed [N];

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [2:0] g;
    logic [1:0] id;
    logic       tp;
  } lane_exp_t;
  typedef lane_exp_t [N-1:0] exp_t;
  exp_t q[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      owner[i] = -1;
      ptr[i]   = 0;
      hold[i]  = 0;
      armed[i] = 1'b0;
    end
  endtask

  task automatic model_step(output exp_t e);
    for (int i = 0; i < N; i++) begin
      logic tp;
      tp = 1'b0;
      if (!armed[i]) begin
        armed[i] = 1'b1;
      end else if (owner[i] < 0) begin
        for (int k = 0; k < sz[i]; k++) begin
          int l;
          l = (ptr[i] + k) % sz[i];
          if (owner[i] < 0 && req[i][l] && mk[i][l]) begin
            owner[i] = l;
            hold[i]  = 0;
          end
        end
      end else begin
        bit rel;
        rel = done[i][owner[i]];
`ifdef MASKED_ARB_TIMEOUT_EN
        if (!rel && hold[i] == TO - 1) begin
          rel = 1'b1;
          tp  = 1'b1;
        end
`endif
        if (rel) begin
          ptr[i]   = (owner[i] + 1) % sz[i];
          owner[i] = -1;
        end else begin
          hold[i]++;
        end
      end
      e[i].g  = (owner[i] >= 0) ? 3'(1 << owner[i]) : 3'b000;
      e[i].id = (owner[i] >= 0) ? 2'(owner[i]) : 2'd0;
      e[i].tp = tp;
    end
  endtask

  task automatic drive(input logic [2:0] r0, d0, r1, d1, r2, d2);
    exp_t e;
    @(negedge clk);
    req[0] = r0; done[0] = d0;
    req[1] = r1; done[1] = d1;
    req[2] = r2; done[2] = d2;
    model_step(e);
    q.push_back(e);
  endtask

  task automatic drive_all(input logic [2:0] r, d);
    drive(r, d, r, d, r, d);
  endtask

  // Owner raises done on its second busy cycle.
  function automatic logic [2:0] auto_done(input int i);
    return (owner[i] >= 0 && hold[i] == 1) ? 3'(1 << owner[i]) : 3'b000;
  endfunction

  task automatic check_idle_outputs(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_gnt[%0d]", tag, i), 32'(gnt[i]), 32'd0);
      chk($sformatf("%s_gv[%0d]", tag, i), 32'(gv[i]), 32'd0);
      chk($sformatf("%s_gid[%0d]", tag, i), 32'(gid[i]), 32'd0);
`ifdef MASKED_ARB_TIMEOUT_EN
      chk($sformatf("%s_tmo[%0d]", tag, i), 32'(tmo[i]), 32'd0);
`endif
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n === 1'b1 && q.size() > 0) begin
      e = q.pop_front();
      for (int i = 0; i < N; i++) begin
        chk($sformatf("gnt[%0d]", i), 32'(gnt[i]), 32'(e[i].g));
        chk($sformatf("gnt_valid[%0d]", i), 32'(gv[i]), 32'(|e[i].g));
        chk($sformatf("gnt_id[%0d]", i), 32'(gid[i]), 32'(e[i].id));
`ifdef MASKED_ARB_TIMEOUT_EN
        chk($sformatf("timeout[%0d]", i), 32'(tmo[i]), 32'(e[i].tp));
`endif
      end
    end
  end

  initial begin
    sz = '{2, 3, 1};
    mk = '{3'b111, 3'b101, 3'b111};
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      req[i]  = 3'b000;
      done[i] = 3'b000;
    end
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(posedge clk);
    #3 rst_n = 1'b1;

    // All lanes requesting, owners release after two cycles.
    repeat (16) drive(3'b111, auto_done(0), 3'b111, auto_done(1), 3'b111, auto_done(2));

    // Only masked/out-of-range lanes requesting, then a legal lane joins.
    drive_all(3'b000, 3'b111);
    drive_all(3'b000, 3'b111);
    repeat (6) drive_all(3'b010, 3'b000);
    repeat (4) drive_all(3'b110, 3'b000);

    // Non-owner done is ignored; owner done releases and advances the pointer.
    drive_all(3'b000, 3'b111);
    drive_all(3'b000, 3'b111);
    repeat (2) drive_all(3'b001, 3'b000);
    repeat (3) drive_all(3'b001, 3'b010);
    drive_all(3'b001, 3'b001);
    repeat (3) drive_all(3'b011, 3'b000);

    // Asynchronous reset in the middle of a grant.
    repeat (2) drive_all(3'b011, 3'b000);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) drive_all(3'b011, 3'b000);

    // Owner never releases: hold forever, or forced release with the timeout.
    drive_all(3'b000, 3'b111);
    drive_all(3'b000, 3'b111);
    repeat (12) drive_all(3'b111, 3'b000);

    // Continuous done: grant every other cycle.
    repeat (8) drive_all(3'b111, 3'b111);

    repeat (3000) begin
      logic [2:0] r [N];
      logic [2:0] d [N];
      for (int i = 0; i < N; i++) begin
        r[i] = 3'($urandom_range(0, 7));
        for (int b = 0; b < 3; b++) d[i][b] = ($urandom_range(0, 2) == 0);
      end
      drive(r[0], d[0], r[1], d[1], r[2], d[2]);
    end

    @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/masked_lane_arbiter.md
# masked_lane_arbiter

Round-robin arbiter that shares one downstream resource among up to `MAX_SIZE` requester lanes. Only lanes with index below `SIZE` and with their `MASK` bit set take part. The lane-enable logic is built with generate-if, and out-of-range `MASK` bits are never indexed. The block sits between the per-lane generate blocks of a `test_gen`-style wrapper and the shared resource, and issues one grant at a time with a request/done handshake.

## Interface
Parameters:
- `MAX_SIZE`, 3 — physical lane count and port width.
- `SIZE`, 3 — active lane count, 1..`MAX_SIZE`.
- `MASK`, `MAX_SIZE'b1…1` — per-lane enable; only bits `[SIZE-1:0]` are read.
- `TIMEOUT`, 15 — maximum hold cycles (used only with the macro).

Ports:
- `clk` input 1 — clock; all state on the rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `req` input `MAX_SIZE` — per-lane request; level-sensitive.
- `done` input `MAX_SIZE` — per-lane release; only the owner's bit is observed.
- `gnt` output `MAX_SIZE` — one-hot grant, registered.
- `gnt_valid` output 1 — a grant is outstanding; equals `|gnt`.
- `gnt_id` output `$clog2(MAX_SIZE)` — index of the owner; 0 when idle.
- `timeout` output 1 — one-cycle pulse on forced release; present only with `MASKED_ARB_TIMEOUT_EN`.

## Operation
- Eligible vector: `elig[g] = req[g]` when `(g < SIZE) && MASK[g]`, else constant 0.
  - Built per lane with generate-if.
  - For `g >= SIZE` the `MASK[g]` term is never elaborated, so no out-of-range select exists.
- FSM states: `IDLE`, `BUSY`.
- IDLE → BUSY when `|elig` is true.
  - Owner is the first eligible lane at or after `ptr`, scanning upward and wrapping from `SIZE-1` to 0.
  - Load `gnt`, `gnt_id` and `owner`.
- BUSY → IDLE when `done[owner]` is 1.
  - Clear `gnt`.
  - Set `ptr` to `owner+1`, or 0 when `owner == SIZE-1`.
- BUSY holds regardless of changes on `req`, including when the owner drops `req` early.
- `done` on any non-owner lane is ignored.
- `ptr` width is `$clog2(MAX_SIZE)`. Reset value is 0, and it is never loaded with a value `>= SIZE`.
- Masked lanes and lanes `>= SIZE` never receive a grant, whatever appears on `req`.
- When `SIZE == 1`, the pointer stays at 0.

## Timing
- Reset values: `gnt = 0`, `gnt_valid = 0`, `gnt_id = 0`, `timeout = 0`, `ptr = 0`, state `IDLE`.
- Grant latency: `req` sampled high in IDLE at edge N gives `gnt` high after edge N (1 cycle).
- Release: `done[owner]` sampled at edge M gives `gnt` low after edge M.
- IDLE lasts at least 1 cycle between grants, so back-to-back owners are separated by one idle cycle.
- If `req` and `done` of the same lane are both high in BUSY, the release wins. Re-arbitration happens in the following IDLE cycle.
- If `rst_n` falls mid-grant, all outputs clear asynchronously. After `rst_n` rises, the first arbitration takes place at the second rising edge.

## Configuration
- `MASKED_ARB_TIMEOUT_EN` defined:
  - A hold counter (width `$clog2(TIMEOUT+1)`) clears on entry to BUSY and increments each BUSY cycle.
  - When the count reaches `TIMEOUT` without `done`, the FSM forces BUSY → IDLE, advances `ptr` as for a normal release, and pulses `timeout` for 1 cycle.
- Undefined:
  - No counter and no `timeout` port.
  - The grant holds until `done`, indefinitely if needed.

## Structure
- Package `masked_arb_pkg`:
  - `arb_state_e` enum (`IDLE`, `BUSY`).
  - `DEFAULT_MAX_SIZE = 3`.
  - Function `lane_enabled(g, size, mask)` returning a 0/1 constant for use in generate.
- Sub-module `rr_pick`:
  - Combinational.
  - Inputs `elig` and `ptr`; outputs one-hot `pick` and `pick_id`.
  - Wrap-around bound is `SIZE`.
  - Instantiated once.

## Test plan
- `SIZE=2`, `MASK=2'b11` (`MAX_SIZE=3`), `req=3'b111` held, `done` pulsed by each owner 2 cycles after its grant → grants alternate lane 0 then lane 1. Lane 2 is never granted, `gnt_id ∈ {0,1}`.
- `SIZE=3`, `MASK=3'b101`, `req=3'b010` → `gnt` stays 0 forever; then `req=3'b110` → lane 2 granted 1 cycle later.
- Owner lane 0 with `done[1]=1` and `done[0]=0` → grant is held; `done[0]=1` → `gnt=0` next cycle; `ptr=1`.
- `rst_n` asserted low during BUSY → outputs 0 immediately. After release, with `req=3'b011`, lane 0 is granted first (ptr reset).
- With `MASKED_ARB_TIMEOUT_EN`, `TIMEOUT=4`, owner never asserts `done` → `timeout` pulses and `gnt` clears after 4 BUSY cycles, and the next eligible lane is granted 1 idle cycle later.
- `SIZE=1`, `MASK=1'b1`, `req[0]` held with `done` every grant → lane 0 is re-granted every other cycle and `ptr` stays 0.
